// File: rtl/rv_ctrl_pkg.sv
// Shared control constants for the multi-cycle RV32I core:
// opcodes, ALUOp codes and main FSM state encodings.
package rv_ctrl_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

endpackage

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences the shared
// ALU, memory and register file and drives ALUOp into the ALU decoder.
module multicycle_main_fsm
   import rv_ctrl_pkg::*;
#(
   parameter bit WAIT_EN  = 1'b1,
   parameter bit TRAP_ILL = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_op,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       reg_write,
   output logic       illegal
);

   state_t state, state_next;
   logic   rdy;
   logic   pc_update;
   logic   branch;

   assign rdy = WAIT_EN ? mem_ready : 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FETCH;
      else     state <= state_next;
   end

   // Whole decode is gated by rst so no strobe can appear while held in reset.
   always_comb begin
      state_next = S_FETCH;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      result_src = RES_ALUOUT;
      alu_op     = ALUOP_ADD;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      pc_update  = 1'b0;
      branch     = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               alu_src_b  = SRCB_FOUR;
               result_src = RES_ALURES;
               ir_write   = rdy;
               pc_update  = rdy;
               state_next = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
               alu_src_a = SRCA_OLDPC;
               alu_src_b = SRCB_IMM;
               case (op)
                  OP_LW, OP_SW: state_next = S_MEMADR;
                  OP_R:         state_next = S_EXECR;
                  OP_I:         state_next = S_EXECI;
                  OP_BEQ:       state_next = S_BEQ;
                  OP_JAL:       state_next = S_JAL;
                  default: begin
                     state_next = S_FETCH;
                     illegal    = TRAP_ILL;
                  end
               endcase
            end
            S_MEMADR: begin
               alu_src_a = SRCA_RS1;
               alu_src_b = SRCB_IMM;
               case (op)
                  OP_LW:   state_next = S_MEMREAD;
                  OP_SW:   state_next = S_MEMWRITE;
                  default: state_next = S_FETCH;
               endcase
            end
            S_MEMREAD: begin
               adr_src    = 1'b1;
               state_next = rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
               result_src = RES_DATA;
               reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
               adr_src    = 1'b1;
               mem_write  = 1'b1;
               state_next = rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
               alu_src_a  = SRCA_RS1;
               alu_op     = ALUOP_FUNCT;
               state_next = S_ALUWB;
            end
            S_EXECI: begin
               alu_src_a  = SRCA_RS1;
               alu_src_b  = SRCB_IMM;
               alu_op     = ALUOP_FUNCT;
               state_next = S_ALUWB;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BEQ: begin
               alu_src_a = SRCA_RS1;
               alu_op    = ALUOP_SUB;
               branch    = 1'b1;
            end
            S_JAL: begin
               alu_src_a  = SRCA_OLDPC;
               alu_src_b  = SRCB_FOUR;
               pc_update  = 1'b1;
               state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
         endcase
      end
   end

   assign pc_write = pc_update | (branch & zero);

endmodule
